nw_output_scheduler: RTL and testbench

Packet-locking round-robin scheduler for one router output port. It shares the output and its downstream buffer credits between `size` input requesters (input VCs or input ports). A requester that wins keeps the port until its tail flit is sent. Flits are only granted while downstream credits remain. It sits after the tree/matrix arbiters in the switch-allocation path. It replaces their per-cycle fairness with packet-granular round-robin plus credit-based flow control.

---
 rtl/nw_output_scheduler_if.sv | 28 ++
 rtl/nw_output_scheduler.sv | 141 ++++++++++++++
 tb/tb_nw_output_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/nw_output_scheduler_if.sv
// rtl/nw_output_scheduler_if.sv - request/grant/credit bundle between requesters and the output scheduler
interface nw_output_scheduler_if #(
    parameter int size         = 8,
    parameter int credit_depth = 4
);
    localparam int cw = $clog2(credit_depth + 1);

    logic [size-1:0] request;
    logic [size-1:0] req_tail;
    logic            credit_in;
    logic [size-1:0] grant;
    logic            locked;
    logic [size-1:0] owner;
    logic [cw-1:0]   credits;
    logic            cred_err;

    // Requester / downstream side
    modport master (
        output request, req_tail, credit_in,
        input  grant, locked, owner, credits, cred_err
    );

    // Scheduler side
    modport slave (
        input  request, req_tail, credit_in,
        output grant, locked, owner, credits, cred_err
    );
endinterface

// File: rtl/nw_output_scheduler.sv
// rtl/nw_output_scheduler.sv - packet-locking round-robin output scheduler with downstream credits
module nw_output_scheduler #(
    parameter int size         = 8,
    parameter int credit_depth = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    nw_output_scheduler_if.slave  bus
);
    localparam int pw = (size > 1) ? $clog2(size) : 1;
    localparam int cw = $clog2(credit_depth + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state_q, state_d;
    logic [size-1:0] owner_q, owner_d;
    logic [pw-1:0]   ptr_q, ptr_d;
    logic [cw-1:0]   credits_q;
    logic            cred_err_q;

    logic [size-1:0] grant_c;
    logic            xfer;
    logic            credit_ok;
    logic            win_found;
    logic [pw-1:0]   win_idx;
    logic [pw-1:0]   owner_idx;

    // Round-robin successor of an index, wrapping size-1 back to 0
    function automatic logic [pw-1:0] ptr_next(input logic [pw-1:0] p);
        return (int'(p) == size - 1) ? '0 : p + 1'b1;
    endfunction

    // First requester at or after ptr, scanning with wrap-around
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < size; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= size) begin
                cand = cand - size;
            end
            if (!win_found && bus.request[cand]) begin
                win_found = 1'b1;
                win_idx   = pw'(cand);
            end
        end
    end

    // Binary index of the one-hot owner
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < size; i++) begin
            if (owner_q[i]) begin
                owner_idx = pw'(i);
            end
        end
    end

    assign credit_ok = (credits_q != '0);

    // Next-state and combinational grant; grant is forced low while reset is held
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_c = '0;
        case (state_q)
            IDLE: begin
                if (credit_ok && win_found) begin
                    grant_c[win_idx] = 1'b1;
                    if (bus.req_tail[win_idx]) begin
                        ptr_d = ptr_next(win_idx);
                    end else begin
                        state_d = LOCKED;
                        owner_d = grant_c;
                    end
                end
            end
            LOCKED: begin
                if (credit_ok) begin
                    grant_c = owner_q & bus.request;
                end
                if ((|grant_c) && (|(owner_q & bus.req_tail))) begin
                    state_d = IDLE;
                    owner_d = '0;
                    ptr_d   = ptr_next(owner_idx);
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
            end
        endcase
        if (rst) begin
            grant_c = '0;
        end
    end

    assign xfer = |grant_c;

    // Arbitration state: FSM, owner and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Credit counter with saturation and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q  <= cw'(credit_depth);
            cred_err_q <= 1'b0;
        end else if (xfer && !bus.credit_in) begin
            credits_q <= credits_q - 1'b1;
        end else if (bus.credit_in && !xfer) begin
            if (credits_q == cw'(credit_depth)) begin
                cred_err_q <= 1'b1;
            end else begin
                credits_q <= credits_q + 1'b1;
            end
        end
    end

    assign bus.grant    = grant_c;
    assign bus.locked   = (state_q == LOCKED);
    assign bus.owner    = owner_q;
    assign bus.credits  = credits_q;
    assign bus.cred_err = cred_err_q;

endmodule

// File: tb/tb_nw_output_scheduler.sv
// tb/tb_nw_output_scheduler.sv - directed self-checking bench for nw_output_scheduler
module tb_nw_output_scheduler;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    nw_output_scheduler_if #(.size(8), .credit_depth(4)) ifc ();

    nw_output_scheduler #(.size(8), .credit_depth(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] req, input logic [7:0] tail, input logic cin);
        ifc.request   = req;
        ifc.req_tail  = tail;
        ifc.credit_in = cin;
        #1;
    endtask

    logic [7:0] rr_exp [5];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rr_exp[0] = 8'h02; rr_exp[1] = 8'h20; rr_exp[2] = 8'h02;
        rr_exp[3] = 8'h20; rr_exp[4] = 8'h02;

        // Reset held, requests present: grant must stay low
        rst = 1'b1;
        ifc.request = 8'hff; ifc.req_tail = 8'h00; ifc.credit_in = 1'b0;
        tick();
        #1;
        check("rst_grant",    ifc.grant,    8'h00);
        check("rst_credits",  ifc.credits,  4);
        check("rst_locked",   ifc.locked,   0);
        check("rst_owner",    ifc.owner,    8'h00);
        check("rst_cred_err", ifc.cred_err, 0);
        ifc.request = 8'h00;
        rst = 1'b0;

        // Overflow: credit return while full
        tick();
        drive(8'h00, 8'h00, 1'b1);
        check("ovf_grant", ifc.grant, 8'h00);
        tick();
        drive(8'h00, 8'h00, 1'b0);
        check("ovf_credits",  ifc.credits,  4);
        check("ovf_cred_err", ifc.cred_err, 1);

        // Round robin between requesters 1 and 5, single-flit packets
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(8'h22, 8'hff, 1'b1);
            check($sformatf("rr_grant%0d", i), ifc.grant, rr_exp[i]);
            tick();
        end
        drive(8'h00, 8'h00, 1'b0);
        check("rr_credits", ifc.credits,  4);
        check("rr_sticky",  ifc.cred_err, 1);

        // Packet lock: requester 2 sends 4 flits while requester 0 waits (ptr=2)
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(8'h05, (i == 3) ? 8'h05 : 8'h01, 1'b1);
            check($sformatf("pk_grant%0d", i), ifc.grant, 8'h04);
            check($sformatf("pk_locked%0d", i), ifc.locked, (i == 0) ? 0 : 1);
            check($sformatf("pk_owner%0d", i), ifc.owner, (i == 0) ? 8'h00 : 8'h04);
            tick();
        end
        drive(8'h01, 8'h01, 1'b1);
        check("pk_next_grant",  ifc.grant,  8'h01);
        check("pk_next_locked", ifc.locked, 0);
        tick();

        // Reset mid-packet: requester 4 locks (ptr=1), then async reset between edges
        drive(8'h10, 8'h00, 1'b0);
        check("mr_grant0", ifc.grant, 8'h10);
        tick();
        drive(8'h10, 8'h00, 1'b0);
        check("mr_locked", ifc.locked, 1);
        check("mr_owner",  ifc.owner,  8'h10);
        check("mr_credits_pre", ifc.credits, 3);
        #2;
        rst = 1'b1;
        #1;
        check("mr_credits",  ifc.credits,  4);
        check("mr_locked0",  ifc.locked,   0);
        check("mr_owner0",   ifc.owner,    8'h00);
        check("mr_grant",    ifc.grant,    8'h00);
        check("mr_cred_err", ifc.cred_err, 0);
        ifc.request = 8'h00;
        tick();
        rst = 1'b0;

        // Credit stall: requester 3 sends 5 flits with no credit return (ptr=0)
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(8'h08, 8'h00, 1'b0);
            check($sformatf("cs_grant%0d", i), ifc.grant, 8'h08);
            tick();
        end
        drive(8'h08, 8'h00, 1'b1);
        check("cs_stall_grant",   ifc.grant,   8'h00);
        check("cs_stall_credits", ifc.credits, 0);
        check("cs_stall_locked",  ifc.locked,  1);
        tick();
        drive(8'h08, 8'h08, 1'b0);
        check("cs_credits1", ifc.credits, 1);
        check("cs_last_grant", ifc.grant, 8'h08);
        tick();
        drive(8'h00, 8'h00, 1'b0);
        check("cs_end_locked",  ifc.locked,  0);
        check("cs_end_credits", ifc.credits, 0);
        check("cs_end_grant",   ifc.grant,   8'h00);

        // Simultaneous transfer and credit return at credits=1 (ptr=4)
        ifc.credit_in = 1'b1;
        tick();
        drive(8'h01, 8'h01, 1'b1);
        check("sim_credits_pre", ifc.credits, 1);
        check("sim_grant",       ifc.grant,   8'h01);
        tick();
        drive(8'h00, 8'h00, 1'b1);
        check("sim_credits", ifc.credits, 1);
        tick();
        tick();
        tick();
        drive(8'h00, 8'h00, 1'b0);
        check("refill_credits", ifc.credits, 4);

        // Pointer wrap: requester 6 moves ptr to 7, then 7 and 0 contend
        drive(8'h40, 8'h40, 1'b1);
        check("wr_grant6", ifc.grant, 8'h40);
        tick();
        drive(8'h81, 8'h81, 1'b1);
        check("wr_grant7", ifc.grant, 8'h80);
        tick();
        drive(8'h81, 8'h81, 1'b1);
        check("wr_grant0", ifc.grant, 8'h01);
        tick();
        drive(8'h00, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
